// File: rtl/dec_round_10_if.sv
// Valid/ready bus for dec_round_10: ciphertext + round-key input channel and result output channel.
interface dec_round_10_if #(
  parameter int BLOCK_LENGTH = 128
);
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [BLOCK_LENGTH-1:0] IN;
  logic [BLOCK_LENGTH-1:0] KEY;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic [BLOCK_LENGTH-1:0] OUT;

  modport master (
    output IN_VALID, IN, KEY, OUT_READY,
    input  IN_READY, OUT_VALID, OUT
  );

  modport slave (
    input  IN_VALID, IN, KEY, OUT_READY,
    output IN_READY, OUT_VALID, OUT
  );
endinterface

// File: rtl/dec_round_10.sv
// Final AES decryption round, OUT = InvSubBytes(InvShiftRows(IN ^ KEY)), as a 2-stage valid/ready pipeline.
// Optional feature macro: DEC_ROUND_10_FLUSH_EN adds a FLUSH input that drops all in-flight blocks.
module dec_round_10 #(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic clk,
  input  logic rst,
`ifdef DEC_ROUND_10_FLUSH_EN
  input  logic FLUSH,
`endif
  dec_round_10_if.slave bus
);

  localparam int NBYTES = BLOCK_LENGTH / 8;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte k of the state (k = 4*col + row) sits at bits [BLOCK_LENGTH-1-8k -: 8]; row r rotates right by r.
  function automatic logic [BLOCK_LENGTH-1:0] inv_shift_rows(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[BLOCK_LENGTH-1-8*(4*c+row) -: 8] = s[BLOCK_LENGTH-1-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] inv_sub_bytes(input logic [BLOCK_LENGTH-1:0] s);
    logic [BLOCK_LENGTH-1:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) begin
      r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    end
    return r;
  endfunction

  logic                    s1_valid_q, s1_valid_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [BLOCK_LENGTH-1:0] s1_data_q,  s1_data_d;
  logic [BLOCK_LENGTH-1:0] s2_data_q,  s2_data_d;
  logic                    flush_s;
  logic                    s1_adv_s;
  logic                    s2_fire_s;
  logic                    in_ready_s;
  logic                    in_take_s;

`ifdef DEC_ROUND_10_FLUSH_EN
  assign flush_s = FLUSH;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake decode; IN_READY never looks at IN_VALID.
  always_comb begin
    s2_fire_s = s2_valid_q & bus.OUT_READY;
    s1_adv_s  = s1_valid_q & (~s2_valid_q | bus.OUT_READY);
    if (flush_s) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = ~s1_valid_q | s1_adv_s;
    end
    in_take_s = bus.IN_VALID & in_ready_s;
  end

  // Stage next-state: data registers change only on a load, flush drops both valid bits.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (flush_s) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_take_s) begin
        s1_valid_d = 1'b1;
        s1_data_d  = inv_shift_rows(bus.IN ^ bus.KEY);
      end else if (s1_adv_s) begin
        s1_valid_d = 1'b0;
      end else begin
        s1_valid_d = s1_valid_q;
      end
      if (s1_adv_s) begin
        s2_valid_d = 1'b1;
        s2_data_d  = inv_sub_bytes(s1_data_q);
      end else if (s2_fire_s) begin
        s2_valid_d = 1'b0;
      end else begin
        s2_valid_d = s2_valid_q;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign bus.IN_READY  = in_ready_s;
  assign bus.OUT_VALID = s2_valid_q;
  assign bus.OUT       = s2_data_q;

endmodule
